// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches from instruction memory and buffers {pc, instr} pairs for IF/ID.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_squashed counters.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrcD_Control,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [63:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [63:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_pc_mem  [FIFO_DEPTH];
  logic [31:0]      r_ins_mem [FIFO_DEPTH];

  logic        w_redirect;
  logic        w_valid;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [63:0] w_target;

  assign w_redirect = PCSrcD_Control;
  assign w_target   = branch_target & ~64'h3;
  assign w_valid    = !rst && (r_count != '0);
  // Redirect suppresses a new request so the stale PC is never fetched.
  assign imem_req   = !rst && (r_state == S_REQ) && (r_count < CNT_W'(FIFO_DEPTH)) && !w_redirect;
  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req && imem_ready;
  assign w_push     = (r_state == S_WAIT) && imem_rvalid && !w_redirect;
  assign w_pop      = w_valid && !stall && !w_redirect;

  assign valid_out       = w_valid;
  assign instruction_out = w_valid ? r_ins_mem[r_rd_ptr] : 32'h0;
  assign pc_out          = w_valid ? r_pc_mem[r_rd_ptr] : 64'h0;

  // Fetch FSM, PC and FIFO pointers; redirect wins over stall, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      case (r_state)
        S_WAIT, S_DRAIN: r_state <= imem_rvalid ? S_REQ : S_DRAIN;
        default:         r_state <= w_accept ? S_DRAIN : S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state    <= S_REQ;
            r_fetch_pc <= r_fetch_pc + 64'd4;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Prefetch storage; no reset needed since valid_out masks empty slots.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
      r_ins_mem[r_wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic        w_discard;
  logic [33:0] w_sq_sum;

  assign w_discard = imem_rvalid && ((r_state == S_DRAIN) || ((r_state == S_WAIT) && w_redirect));
  assign w_sq_sum  = {2'b00, perf_squashed} + (w_redirect ? 34'(r_count) : 34'd0) + 34'(w_discard);

  // Saturating counters: pushes, and dropped responses plus flushed entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (w_push && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      perf_squashed <= (w_sq_sum > 34'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : w_sq_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model plus {pc, instr} scoreboard checked on every pop.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        PCSrcD_Control;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_lat  = 1;
  ent_t exp_q[$];

  logic        m_pend = 1'b0;
  int          m_cnt  = 0;
  logic [63:0] m_addr = 64'h0;

  if_fetch_unit #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrcD_Control(PCSrcD_Control),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_out(valid_out), .instruction_out(instruction_out), .pc_out(pc_out)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    if (a == 64'h0) return 32'h11223344;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1; stall = 1'b0; PCSrcD_Control = 1'b0; imem_ready = 1'b0;
    exp_q.delete();
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  // Memory: accept seen at negedge, response mem_lat cycles later for one cycle.
  always begin
    @(negedge clk);
    if (imem_req && imem_ready) begin
      m_pend = 1'b1;
      m_cnt  = mem_lat;
      m_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_f(m_addr);
        m_pend      = 1'b0;
      end
    end
  end

  // Scoreboard: every pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && valid_out && !stall && !PCSrcD_Control) begin
      chk("sb_expected_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", 64'(instruction_out), 64'(e.ins));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; PCSrcD_Control = 1'b0; branch_target = 64'h0; imem_ready = 1'b1;
    @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_instr", 64'(instruction_out), 64'h0);

    // First fetch with a 1-cycle memory.
    do_reset();
    imem_ready = 1'b1; mem_lat = 1;
    exp_q.push_back('{pc: 64'h0, ins: 32'h11223344});
    @(negedge clk);
    chk("p1_addr0", imem_addr, 64'h0);
    chk("p1_req0", 64'(imem_req), 64'd1);
    next_cyc(); @(negedge clk);
    chk("p1_wait_valid", 64'(valid_out), 64'd0);
    next_cyc(); imem_ready = 1'b0; @(negedge clk);
    chk("p1_valid", 64'(valid_out), 64'd1);
    chk("p1_pc", pc_out, 64'h0);
    chk("p1_instr", 64'(instruction_out), 64'h11223344);
    chk("p1_next_addr", imem_addr, 64'h4);
    chk("p1_next_req", 64'(imem_req), 64'd1);

    // Stall fills the FIFO, then drains in order.
    do_reset();
    stall = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    exp_q.push_back('{pc: 64'h0, ins: mem_f(64'h0)});
    exp_q.push_back('{pc: 64'h4, ins: mem_f(64'h4)});
    repeat (4) next_cyc();
    @(negedge clk);
    chk("p2_full_req", 64'(imem_req), 64'd0);
    chk("p2_full_valid", 64'(valid_out), 64'd1);
    chk("p2_head_pc", pc_out, 64'h0);
    next_cyc(); @(negedge clk);
    chk("p2_full_req2", 64'(imem_req), 64'd0);
    next_cyc(); stall = 1'b0; @(negedge clk);
    chk("p2_pop_req", 64'(imem_req), 64'd0);
    chk("p2_pop0_pc", pc_out, 64'h0);
    next_cyc(); imem_ready = 1'b0; @(negedge clk);
    chk("p2_pop1_pc", pc_out, 64'h4);
    chk("p2_resume_addr", imem_addr, 64'h8);
    chk("p2_resume_req", 64'(imem_req), 64'd1);
    next_cyc(); @(negedge clk);
    chk("p2_empty", 64'(valid_out), 64'd0);

    // Redirect while waiting: stale response drained.
    do_reset();
    imem_ready = 1'b1; mem_lat = 3;
    next_cyc();
    PCSrcD_Control = 1'b1; branch_target = 64'h1234567890ABCDEF;
    @(negedge clk);
    chk("p3_redir_req", 64'(imem_req), 64'd0);
    next_cyc(); PCSrcD_Control = 1'b0; mem_lat = 1; @(negedge clk);
    chk("p3_drain_req", 64'(imem_req), 64'd0);
    chk("p3_drain_valid", 64'(valid_out), 64'd0);
    next_cyc(); @(negedge clk);
    chk("p3_stale_req", 64'(imem_req), 64'd0);
    chk("p3_stale_valid", 64'(valid_out), 64'd0);
    next_cyc(); @(negedge clk);
    chk("p3_target_addr", imem_addr, 64'h1234567890ABCDEC);
    chk("p3_target_req", 64'(imem_req), 64'd1);
    chk("p3_target_valid", 64'(valid_out), 64'd0);
    next_cyc();
    exp_q.push_back('{pc: 64'h1234567890ABCDEC, ins: mem_f(64'h1234567890ABCDEC)});
    @(negedge clk);
    chk("p3_resp_valid", 64'(valid_out), 64'd0);
    next_cyc(); imem_ready = 1'b0; @(negedge clk);
    chk("p3_new_valid", 64'(valid_out), 64'd1);
    chk("p3_new_pc", pc_out, 64'h1234567890ABCDEC);

    // Redirect coinciding with rvalid; target at top of address space wraps.
    do_reset();
    imem_ready = 1'b1; mem_lat = 1;
    next_cyc();
    PCSrcD_Control = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    next_cyc(); PCSrcD_Control = 1'b0; @(negedge clk);
    chk("p4_drop_valid", 64'(valid_out), 64'd0);
    chk("p4_target_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("p4_target_req", 64'(imem_req), 64'd1);
    next_cyc();
    exp_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, ins: mem_f(64'hFFFF_FFFF_FFFF_FFFC)});
    next_cyc(); imem_ready = 1'b0; @(negedge clk);
    chk("p4_top_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("p4_wrap_addr", imem_addr, 64'h0);
    chk("p4_wrap_req", 64'(imem_req), 64'd1);

    // Reset with a request outstanding; the late response must be ignored.
    do_reset();
    stall = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    exp_q.push_back('{pc: 64'h0, ins: mem_f(64'h0)});
    next_cyc(); mem_lat = 3;
    next_cyc(); @(negedge clk);
    chk("p5_head_valid", 64'(valid_out), 64'd1);
    chk("p5_req_addr", imem_addr, 64'h4);
    next_cyc(); rst = 1'b1; imem_ready = 1'b0; exp_q.delete(); @(negedge clk);
    chk("p5_rst_valid", 64'(valid_out), 64'd0);
    chk("p5_rst_req", 64'(imem_req), 64'd0);
    next_cyc(); rst = 1'b0; @(negedge clk);
    chk("p5_post_valid", 64'(valid_out), 64'd0);
    chk("p5_post_addr", imem_addr, 64'h0);
    chk("p5_post_req", 64'(imem_req), 64'd1);
    next_cyc(); @(negedge clk);
    chk("p5_late_rvalid", 64'(imem_rvalid), 64'd1);
    next_cyc(); stall = 1'b0; @(negedge clk);
    chk("p5_late_ignored", 64'(valid_out), 64'd0);

`ifdef FETCH_PERF_EN
    // Three fetches, one pop, then a redirect flushing two entries.
    do_reset();
    stall = 1'b1; imem_ready = 1'b1; mem_lat = 1;
    exp_q.push_back('{pc: 64'h0, ins: mem_f(64'h0)});
    @(negedge clk);
    chk("p6_fetched_rst", 64'(perf_fetched), 64'd0);
    chk("p6_squashed_rst", 64'(perf_squashed), 64'd0);
    repeat (4) next_cyc();
    stall = 1'b0;
    next_cyc(); stall = 1'b1;
    next_cyc();
    next_cyc(); PCSrcD_Control = 1'b1; branch_target = 64'h40; exp_q.delete();
    next_cyc(); PCSrcD_Control = 1'b0; imem_ready = 1'b0; @(negedge clk);
    chk("p6_fetched", 64'(perf_fetched), 64'd3);
    chk("p6_squashed", 64'(perf_squashed), 64'd2);
    chk("p6_flushed_valid", 64'(valid_out), 64'd0);
`endif

    next_cyc(); next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
